// File: rtl/msg_pkg.sv
// Shared frame constants and parser state encoding for the message link.
// Used by the receive-side parser and the transmit-side frame builder.
package msg_pkg;

  localparam logic [7:0] HDR_WR  = 8'h5A;
  localparam logic [7:0] HDR_RD  = 8'h5B;
  localparam logic [7:0] TAIL_WR = 8'hA5;
  localparam logic [7:0] TAIL_RD = 8'hA4;

  localparam int FRAME_LEN = 10;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd200;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DATA,
    ST_TAIL,
    ST_EXEC,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/msg_timeout.sv
// Frame/ack watchdog: counts enable ticks until LIMIT, cleared on demand.
// Built only when MSG_PARSER_TIMEOUT_EN is defined.
`ifdef MSG_PARSER_TIMEOUT_EN
module msg_timeout
  import msg_pkg::*;
#(
  parameter logic [15:0] LIMIT = TIMEOUT_DEFAULT
) (
  input  logic OPB_CLK,
  input  logic OPB_RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule
`endif

// File: rtl/msg_parser.sv
// Byte-stream frame decoder driving OPB write/read requests.
// Optional watchdog via MSG_PARSER_TIMEOUT_EN.
module msg_parser
  import msg_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_LIMIT = TIMEOUT_DEFAULT
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        PULSE_2KHZ,
  input  logic [7:0]  RX_FIFO_DATA,
  input  logic        RX_FIFO_EMPTY,
  output logic        RX_FIFO_RD,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  output logic        OPB_WE,
  output logic        OPB_RE,
  input  logic        OPB_ACK,
  input  logic [31:0] OPB_DI,
  output logic [31:0] RD_DATA,
  output logic        RD_VALID,
  output logic        error_flag,
  output logic [7:0]  ERR_CNT
);

  state_t      state;
  logic [3:0]  cnt;
  logic        pend;
  logic        is_read;
  logic [31:0] addr_sh;
  logic [31:0] data_sh;
  logic        timeout;
  logic        active;
  logic        take_state;
  logic [7:0]  tail_exp;

  assign active = (state == ST_ADDR) || (state == ST_DATA) ||
                  (state == ST_TAIL) || (state == ST_EXEC);

  assign take_state = (state == ST_HUNT) || (state == ST_ADDR) ||
                      (state == ST_DATA) || (state == ST_TAIL);

  // One pop in flight: the popped byte is consumed while pend is high.
  assign RX_FIFO_RD = !OPB_RST && take_state && !RX_FIFO_EMPTY &&
                      !pend && !timeout;

  assign tail_exp = is_read ? TAIL_RD : TAIL_WR;

`ifdef MSG_PARSER_TIMEOUT_EN
  msg_timeout #(
    .LIMIT (TIMEOUT_LIMIT)
  ) u_timeout (
    .OPB_CLK (OPB_CLK),
    .OPB_RST (OPB_RST),
    .clr     (state == ST_HUNT),
    .en      (PULSE_2KHZ && active),
    .expired (timeout)
  );
`else
  logic unused_tick;
  assign unused_tick = PULSE_2KHZ ^ (|TIMEOUT_LIMIT);
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state      <= ST_HUNT;
      cnt        <= '0;
      pend       <= 1'b0;
      is_read    <= 1'b0;
      addr_sh    <= '0;
      data_sh    <= '0;
      OPB_ADDR   <= '0;
      OPB_DO     <= '0;
      OPB_WE     <= 1'b0;
      OPB_RE     <= 1'b0;
      RD_DATA    <= '0;
      RD_VALID   <= 1'b0;
      error_flag <= 1'b0;
      ERR_CNT    <= '0;
    end else begin
      pend       <= RX_FIFO_RD;
      RD_VALID   <= 1'b0;
      error_flag <= 1'b0;
      if (timeout && active) begin
        state  <= ST_ERROR;
        OPB_WE <= 1'b0;
        OPB_RE <= 1'b0;
      end else begin
        case (state)
          ST_HUNT: begin
            cnt <= '0;
            if (pend) begin
              if (RX_FIFO_DATA == HDR_WR) begin
                is_read <= 1'b0;
                state   <= ST_ADDR;
              end else if (RX_FIFO_DATA == HDR_RD) begin
                is_read <= 1'b1;
                state   <= ST_ADDR;
              end
            end
          end
          ST_ADDR: begin
            if (pend) begin
              addr_sh <= {addr_sh[23:0], RX_FIFO_DATA};
              cnt     <= cnt + 4'd1;
              if (cnt == 4'd3) begin
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (pend) begin
              data_sh <= {data_sh[23:0], RX_FIFO_DATA};
              cnt     <= cnt + 4'd1;
              if (cnt == 4'(FRAME_LEN - 3)) begin
                state <= ST_TAIL;
              end
            end
          end
          ST_TAIL: begin
            if (pend) begin
              if (RX_FIFO_DATA == tail_exp) begin
                OPB_ADDR <= addr_sh;
                OPB_DO   <= is_read ? 32'd0 : data_sh;
                state    <= ST_EXEC;
              end else begin
                state <= ST_ERROR;
              end
            end
          end
          ST_EXEC: begin
            // First EXEC cycle raises the request; later cycles wait for ack.
            if (!OPB_WE && !OPB_RE) begin
              OPB_WE <= !is_read;
              OPB_RE <= is_read;
            end else if (OPB_ACK) begin
              OPB_WE <= 1'b0;
              OPB_RE <= 1'b0;
              cnt    <= '0;
              state  <= ST_HUNT;
              if (is_read) begin
                RD_DATA  <= OPB_DI;
                RD_VALID <= 1'b1;
              end
            end
          end
          ST_ERROR: begin
            error_flag <= 1'b1;
            if (ERR_CNT != 8'hFF) begin
              ERR_CNT <= ERR_CNT + 8'd1;
            end
            cnt   <= '0;
            state <= ST_HUNT;
          end
          default: begin
            state <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msg_parser.sv
// Scoreboard bench for msg_parser: random frames, FIFO and OPB slave models.
// Timeout scenarios run when MSG_PARSER_TIMEOUT_EN is defined.
module tb_msg_parser;
  import msg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse = 1'b0;
  logic [7:0]  fdata = 8'h00;
  logic        empty = 1'b1;
  logic        fifo_rd;
  logic [31:0] opb_addr, opb_do, rd_data, di = 32'h0;
  logic        opb_we, opb_re, rd_valid, err_flag;
  logic        ack = 1'b0;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  msg_parser dut (
    .OPB_CLK       (clk),
    .OPB_RST       (rst),
    .PULSE_2KHZ    (pulse),
    .RX_FIFO_DATA  (fdata),
    .RX_FIFO_EMPTY (empty),
    .RX_FIFO_RD    (fifo_rd),
    .OPB_ADDR      (opb_addr),
    .OPB_DO        (opb_do),
    .OPB_WE        (opb_we),
    .OPB_RE        (opb_re),
    .OPB_ACK       (ack),
    .OPB_DI        (di),
    .RD_DATA       (rd_data),
    .RD_VALID      (rd_valid),
    .error_flag    (err_flag),
    .ERR_CNT       (err_cnt)
  );

  typedef struct {
    byte unsigned kind;
    logic [31:0]  addr;
    logic [31:0]  data;
  } ev_t;

  ev_t          exp_q[$];
  logic [31:0]  rd_q[$];
  byte unsigned fq[$];
  int           checks = 0;
  int           errors = 0;
  int           model_err = 0;
  bit           stall = 0;
  bit           stall_rand = 0;
  bit           ack_en = 1;
  int           ack_fix = -1;
  bit           di_fix = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: frame rules -> byte stream plus expected event list.
  task automatic send_frame(bit rd, logic [31:0] a, logic [31:0] d,
                            bit bad);
    ev_t e;
    fq.push_back(rd ? HDR_RD : HDR_WR);
    for (int i = 3; i >= 0; i--) fq.push_back(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fq.push_back(d[i*8 +: 8]);
    if (bad) fq.push_back(rd ? TAIL_WR : TAIL_RD);
    else     fq.push_back(rd ? TAIL_RD : TAIL_WR);
    e.addr = a;
    e.data = d;
    if (bad) begin
      e.kind = "E";
      if (model_err < 255) model_err++;
    end else begin
      e.kind = rd ? "R" : "W";
    end
    exp_q.push_back(e);
  endtask

  task automatic send_garbage(int n);
    byte unsigned b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == HDR_WR || b == HDR_RD) b = b ^ 8'h80;
      fq.push_back(b);
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || rd_q.size() != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got fifo=%0d events=%0d required 0",
               fq.size(), exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_addr"}, opb_addr, 32'h0);
    chk({tag, "_do"}, opb_do, 32'h0);
    chk({tag, "_rd_data"}, rd_data, 32'h0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
    chk({tag, "_strobes"}, {27'h0, opb_we, opb_re, rd_valid, err_flag,
                            fifo_rd}, 32'h0);
  endtask

  // FIFO model: pop on RX_FIFO_RD, data valid next cycle.
  initial begin
    byte unsigned b;
    forever begin
      @(posedge clk);
      if (fifo_rd) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL pop_empty: got pop required none");
        end else begin
          b = fq.pop_front();
          #1 fdata = b;
        end
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      pulse = (cyc % 4 == 0);
      if (stall_rand && ($urandom_range(0, 3) == 0)) stall = ~stall;
      empty = (fq.size() == 0) || stall;
    end
  end

  // OPB slave: ack after a short delay, reads return fresh data.
  initial begin
    int wcnt;
    int dly;
    wcnt = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack = 1'b0;
        wcnt = 0;
      end else if (ack) begin
        ack = 1'b0;
      end else if ((opb_we || opb_re) && ack_en) begin
        if (wcnt == 0) dly = (ack_fix >= 0) ? ack_fix : $urandom_range(0, 3);
        if (wcnt >= dly) begin
          ack = 1'b1;
          di = di_fix ? 32'h12345678 : $urandom;
          if (opb_re) rd_q.push_back(di);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compare observed requests, errors and read returns.
  initial begin
    logic        we_q, re_q;
    logic [31:0] h_addr, h_do;
    ev_t         e;
    we_q = 0;
    re_q = 0;
    h_addr = 0;
    h_do = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_q = 0;
        re_q = 0;
      end else begin
        if (opb_we && opb_re) begin
          chk("we_re_exclusive", 32'({opb_we, opb_re}), 32'h0);
        end
        if ((opb_we && !we_q) || (opb_re && !re_q)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: got addr %h required none",
                     opb_addr);
          end else begin
            e = exp_q.pop_front();
            chk("req_kind", 32'(opb_we ? "W" : "R"), 32'(e.kind));
            chk("req_addr", opb_addr, e.addr);
            if (opb_we) chk("req_data", opb_do, e.data);
          end
          h_addr = opb_addr;
          h_do = opb_do;
        end else if (opb_we || opb_re) begin
          chk("req_stable", (opb_addr ^ h_addr) | (opb_do ^ h_do), 32'h0);
        end
        if (err_flag) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_err: got error_flag required none");
          end else begin
            e = exp_q.pop_front();
            chk("err_kind", 32'("E"), 32'(e.kind));
            chk("err_no_req", 32'({opb_we, opb_re}), 32'h0);
          end
        end
        if (rd_valid) begin
          chk("rd_align", 32'({re_q, opb_re}), 32'h2);
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rd: got %h required none", rd_data);
          end else begin
            chk("rd_data", rd_data, rd_q.pop_front());
          end
        end
        we_q = opb_we;
        re_q = opb_re;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    ack_fix = 3;
    send_frame(0, 32'h00001004, 32'hDEADBEEF, 0);
    drain(500);
    chk("write_err_cnt", 32'(err_cnt), 32'h0);
    ack_fix = -1;

    di_fix = 1;
    send_frame(1, 32'h00002000, 32'h11223344, 0);
    drain(500);
    chk("read_rd_data", rd_data, 32'h12345678);
    di_fix = 0;

    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    fq.push_back(8'hA5);
    send_frame(0, 32'hCAFE0010, 32'h01020304, 0);
    drain(500);
    chk("garbage_err_cnt", 32'(err_cnt), 32'h0);

    send_frame(0, 32'h00000040, 32'h55AA55AA, 1);
    drain(500);
    chk("badtail_err_cnt", 32'(err_cnt), 32'(model_err));
    send_frame(0, 32'h00000044, 32'hA5A5A5A5, 0);
    drain(500);
    chk("after_err_cnt", 32'(err_cnt), 32'(model_err));

    fq.push_back(HDR_WR);
    fq.push_back(8'h00);
    fq.push_back(8'h00);
    fq.push_back(8'h30);
    fq.push_back(8'h00);
    fq.push_back(8'h99);
    repeat (20) @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_zero_outputs("midframe_reset");
    model_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(0, 32'h00003000, 32'h87654321, 0);
    drain(500);
    chk("post_reset_err_cnt", 32'(err_cnt), 32'h0);

`ifdef MSG_PARSER_TIMEOUT_EN
    begin
      ev_t e;
      fq.push_back(HDR_WR);
      for (int i = 0; i < 4; i++) fq.push_back(8'(i));
      e.kind = "E";
      e.addr = 0;
      e.data = 0;
      exp_q.push_back(e);
      model_err++;
      drain(3000);
      chk("frame_timeout_cnt", 32'(err_cnt), 32'(model_err));
      send_frame(1, 32'h00004000, 32'h0, 0);
      drain(500);
      ack_en = 0;
      send_frame(0, 32'h00005000, 32'h13579BDF, 0);
      e.kind = "E";
      exp_q.push_back(e);
      model_err++;
      drain(3000);
      ack_en = 1;
      chk("ack_timeout_cnt", 32'(err_cnt), 32'(model_err));
    end
`endif

    stall_rand = 1;
    for (int i = 0; i < 40; i++) begin
      send_garbage($urandom_range(0, 3));
      send_frame(1'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 7) == 0));
    end
    drain(8000);
    stall_rand = 0;
    stall = 0;
    drain(200);
    chk("random_err_cnt", 32'(err_cnt), 32'(model_err));
    chk("final_idle", 32'({opb_we, opb_re}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_parser.md
MSG_PARSER -- requirements
Module: msg_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_LIMIT, default 16'd200, meaning PULSE_2KHZ ticks allowed per frame or OPB ack wait (100 ms).
REQ-002 SHALL have port OPB_CLK  in  1  system clock, all logic rising-edge.
REQ-003 SHALL have port OPB_RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port PULSE_2KHZ  in  1  single-OPB_CLK-cycle tick strobe, sampled synchronously as an enable.
REQ-005 SHALL have port RX_FIFO_DATA  in  8  FIFO read data, valid the cycle after RX_FIFO_RD.
REQ-006 SHALL have port RX_FIFO_EMPTY  in  1  FIFO empty flag.
REQ-007 SHALL have port RX_FIFO_RD  out  1  FIFO pop strobe.
REQ-008 SHALL have port OPB_ADDR  out  32  decoded address.
REQ-009 SHALL have port OPB_DO  out  32  decoded write data.
REQ-010 SHALL have port OPB_WE / OPB_RE  out  1 each  OPB write/read request.
REQ-011 SHALL have port OPB_ACK  in  1  OPB transfer acknowledge.
REQ-012 SHALL have port OPB_DI  in  32  OPB read data, valid with OPB_ACK.
REQ-013 SHALL have port RD_DATA / RD_VALID  out  32 / 1  captured read data and its one-cycle strobe.
REQ-014 SHALL have port error_flag / ERR_CNT  out  1 / 8  one-cycle error pulse and saturating error count.

Function
REQ-015 SHALL decode 10-byte frames: header, 4 address bytes (MSB first), 4 data bytes (MSB first), tail.
REQ-016 Write frame SHALL use header 0x5A with tail 0xA5; read frame SHALL use header 0x5B with tail 0xA4; read-frame data bytes SHALL be consumed and ignored.
REQ-017 RX_FIFO_RD SHALL assert only when RX_FIFO_EMPTY=0 and the state accepts a byte, with at most one pop in flight; the byte SHALL be taken the following cycle.
REQ-018 The FSM SHALL use states HUNT, ADDR, DATA, TAIL, EXEC, ERROR (EXEC covers the OPB request and ack wait).
REQ-019 In HUNT, bytes other than 0x5A/0x5B SHALL be discarded silently; a valid header SHALL latch the frame type and move to ADDR.
REQ-020 ADDR and DATA SHALL each shift in exactly 4 bytes, counted by a 4-bit byte counter that clears on HUNT entry.
REQ-021 In TAIL, a mismatching tail byte (e.g. 0xA4 on a write frame) SHALL go to ERROR with no OPB request issued.
REQ-022 On a correct tail, OPB_ADDR and OPB_DO SHALL update together, and OPB_WE or OPB_RE SHALL assert on the next cycle.
REQ-023 The request SHALL hold, with ADDR/DO stable, until OPB_ACK=1, then deassert on the following cycle; the FSM SHALL then return to HUNT.
REQ-024 OPB_ACK outside EXEC SHALL be ignored.
REQ-025 On a read-frame ack, RD_DATA SHALL capture OPB_DI and RD_VALID SHALL pulse one cycle, aligned with request deassert.
REQ-026 ERROR SHALL last one cycle: error_flag=1, ERR_CNT+1 saturating at 255, then HUNT; no bytes SHALL be popped in ERROR.
REQ-027 OPB_WE and OPB_RE SHALL never be asserted simultaneously.

Reset
REQ-028 OPB_RST SHALL force, asynchronously: state HUNT, byte counter 0, timeout counter 0, and all outputs 0 (OPB_ADDR, OPB_DO, RD_DATA, ERR_CNT, strobes, error_flag).
REQ-029 Reset mid-frame or mid-EXEC SHALL abandon the frame with no OPB request afterwards and no error counted; decoding SHALL restart at HUNT.

Configuration
REQ-030 With macro MSG_PARSER_TIMEOUT_EN defined, a 16-bit counter SHALL clear in HUNT and on frame start and increment on PULSE_2KHZ in ADDR/DATA/TAIL/EXEC.
REQ-031 With MSG_PARSER_TIMEOUT_EN defined, reaching TIMEOUT_LIMIT SHALL go to ERROR and drop any pending OPB request.
REQ-032 Without MSG_PARSER_TIMEOUT_EN, no timeout counter SHALL exist, PULSE_2KHZ SHALL be unused, and a stalled frame or ack SHALL wait indefinitely.

Structure
REQ-033 Shared package msg_pkg SHALL hold the header/tail constants (0x5A, 0x5B, 0xA5, 0xA4), the frame length 10, the state encoding, and the TIMEOUT_LIMIT default, shared with the transmit-side builder.
REQ-034 One sub-module, msg_timeout (tick counter with clear/enable/expired), SHALL exist only under MSG_PARSER_TIMEOUT_EN.

Verification
REQ-035 Bytes 5A 00 00 10 04 DE AD BE EF A5 with ACK 3 cycles after request -> one OPB_WE hold with OPB_ADDR=0x00001004, OPB_DO=0xDEADBEEF; ERR_CNT=0.
REQ-036 Bytes 5B 00 00 20 00 11 22 33 44 A4 with ACK and OPB_DI=0x12345678 -> OPB_RE, OPB_ADDR=0x00002000, RD_VALID pulse with RD_DATA=0x12345678.
REQ-037 Bytes 00 FF A5 followed by a valid write frame -> 3 leading bytes discarded; exactly one OPB_WE; no error.
REQ-038 Write frame ending in A4 -> error_flag one pulse, ERR_CNT=1, no OPB_WE; next valid frame executes normally.
REQ-039 With TIMEOUT_EN: 5 bytes of a frame, then FIFO empty for 200 ticks -> error_flag; a later valid frame decodes. Separately, ACK never given -> request dropped at timeout, ERR_CNT increments.
REQ-040 OPB_RST pulsed after byte 6 of a write frame -> no OPB_WE, outputs 0, a following full frame executes.
